// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: reset PC default, PC step and the
// layout of one prefetch entry ({pc, instr}).
package fetch_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Instructions are one word; the PC always advances by a full word.
    localparam int INSTR_ALIGN = 4;

    // Layout of a prefetch entry at the default XLEN; the pc sits in the upper half.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
    } fetch_entry_t;

    // Width of one prefetch entry for an arbitrary XLEN.
    function automatic int entry_width(input int xlen);
        return 2 * xlen;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the redirect, instruction-memory and decode-side signals of the
// fetch stage.
//
// Handshake rule for every valid/ready pair here: a transfer happens on a
// rising clk edge where both valid and ready are 1; valid never depends on
// ready. The one exception is mem_rsp_valid, which has no ready: the fetch
// unit always takes a response in the cycle it is presented.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;

    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;

    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr_out;
    logic [XLEN-1:0] instr_pc;

    // Fetch unit side.
    modport master (
        input  redirect_valid, redirect_pc,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data,
        output instr_valid, instr_out, instr_pc,
        input  instr_ready
    );

    // Environment side: memory, decode and redirect source.
    modport slave (
        output redirect_valid, redirect_pc,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data,
        input  instr_valid, instr_out, instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push, pop and flush. Head data is read directly from
// registered storage, so an entry becomes visible the cycle after its push.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the same cycle frees the head slot.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Entry storage; cleared on reset so the head reads as zero when empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; flush overrides any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(do_push);
            rd_ptr <= rd_ptr + PTR_W'(do_pop);
            count  <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned requests to a
// variable-latency in-order memory, buffers responses with their PCs in a
// prefetch FIFO and hands them to decode. A redirect flushes the FIFO and
// marks every in-flight response for discard.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF),
    parameter int              FIFO_DEPTH = 4,
    parameter int              CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    localparam int ENTRY_W = entry_width(XLEN);
    // Wide enough for the sum of three CNT_W counters.
    localparam int SUM_W   = CNT_W + 2;

    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    rsp_pc;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   discard;
    logic [CNT_W-1:0]   outstanding_next;
    logic [CNT_W-1:0]   discard_next;
    logic [CNT_W-1:0]   fifo_count;
    logic [SUM_W-1:0]   credit_used;
    logic               fifo_full;
    logic               fifo_empty;
    logic               req_fire;
    logic               rsp_keep;
    logic               rsp_drop;
    logic               push;
    logic               pop;
    logic [XLEN-1:0]    target_pc;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Every slot is reserved at request time: buffered entries, live requests
    // and requests whose responses will be thrown away all hold a credit, so
    // a response always finds room in the FIFO.
    assign credit_used = SUM_W'(fifo_count) + SUM_W'(outstanding) + SUM_W'(discard);

    assign bus.mem_req_valid = rst && !bus.redirect_valid
                               && (credit_used < SUM_W'(FIFO_DEPTH));
    assign bus.mem_req_addr  = {fetch_pc[XLEN-1:2], 2'b00};
    assign req_fire          = bus.mem_req_valid && bus.mem_req_ready;

    // Responses arrive in request order, so stale ones are always the oldest.
    assign rsp_keep = bus.mem_rsp_valid && (discard == '0);
    assign rsp_drop = bus.mem_rsp_valid && (discard != '0);

    assign push      = rsp_keep && !bus.redirect_valid;
    assign pop       = !fifo_empty && bus.instr_ready && !bus.redirect_valid;
    assign target_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign wr_entry  = {rsp_pc, bus.mem_rsp_data};

    assign bus.instr_valid = !fifo_empty;
    assign bus.instr_pc    = rd_entry[ENTRY_W-1:XLEN];
    assign bus.instr_out   = rd_entry[XLEN-1:0];

    // Next values of the in-flight counters; a redirect converts all live
    // requests into discards, less the response retiring this very cycle.
    always_comb begin
        outstanding_next = outstanding;
        discard_next     = discard;
        if (bus.redirect_valid) begin
            discard_next     = discard + outstanding - CNT_W'(bus.mem_rsp_valid);
            outstanding_next = '0;
        end else begin
            outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_keep);
            discard_next     = discard - CNT_W'(rsp_drop);
        end
    end

    // PC registers and in-flight counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            discard     <= discard_next;
            if (bus.redirect_valid) begin
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(INSTR_ALIGN);
                end
                if (rsp_keep) begin
                    rsp_pc <= rsp_pc + XLEN'(INSTR_ALIGN);
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (bus.redirect_valid),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A response with nothing in flight means the memory duplicated or invented a reply.
    assert property (@(posedge clk) disable iff (!rst)
        !(bus.mem_rsp_valid && (outstanding == '0) && (discard == '0)));

    // The credit scheme must never let a push land on a full FIFO.
    assert property (@(posedge clk) disable iff (!rst)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized phase, checked
// against a reference model built from request/response queues with an epoch
// tag per request (a redirect starts a new epoch; older responses are stale).
module tb_fetch_unit;

    localparam int          XLEN       = 32;
    localparam int          DEPTH      = 4;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    logic clk;
    logic rst;

    fetch_unit_if #(.XLEN(XLEN)) bus ();

    fetch_unit #(
        .XLEN       (XLEN),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counters for the summary line.
    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [XLEN-1:0] exp_q[$];        // PCs the decode side should see, in order
    logic [XLEN-1:0] addr_q[$];       // requests accepted, response not yet returned
    int              epoch_q[$];      // epoch each in-flight request belongs to
    int              due_q[$];        // earliest cycle its response may be returned
    logic [XLEN-1:0] exp_req_addr;    // next address the fetcher must request
    int              epoch   = 0;
    int              cyc     = 0;
    int              lat_min = 1;
    int              lat_max = 1;
    int              accepts = 0;
    int              pops    = 0;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model(input logic [XLEN-1:0] start);
        exp_q.delete();
        addr_q.delete();
        epoch_q.delete();
        due_q.delete();
        exp_req_addr = start;
        epoch++;
    endtask

    task automatic drive_idle();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_rsp_valid  = 1'b0;
        bus.mem_rsp_data   = '0;
        bus.instr_ready    = 1'b0;
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step(input logic redir, input logic [XLEN-1:0] tgt,
                        input logic rdy, input logic ir);
        logic            rsp_v;
        logic            rsp_cur;
        logic            exp_rv;
        logic            do_pop;
        logic [XLEN-1:0] rsp_a;
        int              ep;
        rsp_cur = 1'b0;
        rsp_a   = '0;
        // Registered decode-side outputs.
        check("instr_valid", 32'(bus.instr_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("instr_pc", bus.instr_pc, exp_q[0]);
            check("instr_out", bus.instr_out, mem_word(exp_q[0]));
        end
        rsp_v = (addr_q.size() != 0) && (due_q[0] <= cyc);
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;
        bus.mem_req_ready  = rdy;
        bus.instr_ready    = ir;
        bus.mem_rsp_valid  = rsp_v;
        bus.mem_rsp_data   = rsp_v ? mem_word(addr_q[0]) : $urandom;
        #1;
        exp_rv = !redir && ((exp_q.size() + addr_q.size()) < DEPTH);
        check("mem_req_valid", 32'(bus.mem_req_valid), 32'(exp_rv));
        if (exp_rv) begin
            check("mem_req_addr", bus.mem_req_addr, exp_req_addr);
        end
        do_pop = (exp_q.size() != 0) && ir;
        @(posedge clk);
        if (rsp_v) begin
            rsp_a   = addr_q.pop_front();
            ep      = epoch_q.pop_front();
            rsp_cur = (ep == epoch);
            void'(due_q.pop_front());
        end
        if (redir) begin
            exp_q.delete();
            epoch++;
            exp_req_addr = {tgt[XLEN-1:2], 2'b00};
        end else begin
            if (do_pop) begin
                void'(exp_q.pop_front());
                pops++;
            end
            if (rsp_v && rsp_cur) begin
                exp_q.push_back(rsp_a);
            end
            if (exp_rv && rdy) begin
                addr_q.push_back(exp_req_addr);
                epoch_q.push_back(epoch);
                due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
                exp_req_addr = exp_req_addr + 32'd4;
                accepts++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    // Stimulus and checks.
    initial begin
        logic            seen;
        logic [XLEN-1:0] tgt;
        rst = 1'b0;
        drive_idle();
        clear_model(RESET_PC);
        repeat (2) @(negedge clk);

        // Reset values.
        check("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr_out", bus.instr_out, 32'd0);
        check("rst_instr_pc", bus.instr_pc, 32'd0);
        check("rst_req_addr", bus.mem_req_addr, RESET_PC);
        rst = 1'b1;

        // Free run, 1-cycle memory, decode always ready: one instruction per cycle.
        lat_min = 1; lat_max = 1; pops = 0;
        repeat (40) step(1'b0, '0, 1'b1, 1'b1);
        check("freerun_throughput", 32'(pops >= 36), 32'd1);

        // Decode stalled: exactly DEPTH requests, then drain from 0x0 and resume at 0x10.
        step(1'b1, 32'h0, 1'b1, 1'b0);
        accepts = 0;
        repeat (12) step(1'b0, '0, 1'b1, 1'b0);
        check("stall_accepts", 32'(accepts), 32'(DEPTH));
        check("stall_head_pc", bus.instr_pc, 32'h0);
        repeat (16) step(1'b0, '0, 1'b1, 1'b1);

        // 3-cycle memory, two in flight at 0x20/0x24, redirect to 0x103.
        lat_min = 3; lat_max = 3;
        step(1'b1, 32'h20, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("inflight_two", 32'(addr_q.size()), 32'd2);
        step(1'b1, 32'h103, 1'b1, 1'b0);
        check("redir_req_addr", bus.mem_req_addr, 32'h100);
        for (int i = 0; i < 12 && !bus.instr_valid; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("redir_first_valid", 32'(bus.instr_valid), 32'd1);
        check("redir_first_pc", bus.instr_pc, 32'h100);
        repeat (10) step(1'b0, '0, 1'b1, 1'b1);

        // Redirect coinciding with a response and a pop.
        lat_min = 2; lat_max = 2; seen = 1'b0;
        step(1'b1, 32'h400, 1'b1, 1'b1);
        for (int i = 0; i < 30 && !seen; i++) begin
            if (addr_q.size() != 0 && due_q[0] <= cyc && exp_q.size() != 0) begin
                seen = 1'b1;
                step(1'b1, 32'h800, 1'b1, 1'b1);
            end else begin
                step(1'b0, '0, 1'b1, 1'b1);
            end
        end
        check("redir_rsp_pop_seen", 32'(seen), 32'd1);
        check("redir_rsp_pop_empty", 32'(bus.instr_valid), 32'd0);
        repeat (20) step(1'b0, '0, 1'b1, 1'b1);

        // Address wrap across 2^32.
        lat_min = 1; lat_max = 2;
        step(1'b1, 32'hFFFF_FFF5, 1'b1, 1'b1);
        repeat (24) step(1'b0, '0, 1'b1, 1'b1);

        // Randomized traffic with random latency, back-pressure and redirects.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99, 0) < 5) begin
                tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15, 0)))
                                                  : 32'($urandom);
                step(1'b1, tgt, $urandom_range(99, 0) < 70, $urandom_range(99, 0) < 60);
            end else begin
                step(1'b0, '0, $urandom_range(99, 0) < 70, $urandom_range(99, 0) < 60);
            end
        end

        // Asynchronous reset in the middle of traffic.
        lat_min = 5; lat_max = 5;
        step(1'b1, 32'h40, 1'b1, 1'b0);
        repeat (6) step(1'b0, '0, 1'b1, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check("async_rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("async_rst_instr_out", bus.instr_out, 32'd0);
        check("async_rst_instr_pc", bus.instr_pc, 32'd0);
        check("async_rst_req_addr", bus.mem_req_addr, RESET_PC);
        drive_idle();
        clear_model(RESET_PC);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_req_valid", 32'(bus.mem_req_valid), 32'd1);
        check("post_rst_req_addr", bus.mem_req_addr, RESET_PC);
        lat_min = 1; lat_max = 3;
        repeat (30) step(1'b0, '0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
